// File: rtl/sseg_pkg.sv
// Shared constants and helpers for the seven-segment ASCII scanner.
// Segment vectors are active-low, bit order {g,f,e,d,c,b,a}.
package sseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_EIGHT = 7'b0000000;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_T     = 7'b0000111;

  function automatic logic [6:0] ascii_to_seg(input logic [7:0] ch);
    logic [7:0] c;
    logic [6:0] s;
    c = (ch >= 8'h41 && ch <= 8'h5A) ? ch + 8'h20 : ch;
    case (c)
      "0":     s = SEG_ZERO;
      "1":     s = 7'b1111001;
      "2":     s = 7'b0100100;
      "3":     s = 7'b0110000;
      "4":     s = 7'b0011001;
      "5":     s = 7'b0010010;
      "6":     s = 7'b0000010;
      "7":     s = 7'b1111000;
      "8":     s = SEG_EIGHT;
      "9":     s = 7'b0010000;
      " ":     s = SEG_BLANK;
      "-":     s = SEG_DASH;
      "_":     s = 7'b1110111;
      "a":     s = SEG_A;
      "b":     s = 7'b0000011;
      "c":     s = 7'b0100111;
      "d":     s = SEG_D;
      "e":     s = 7'b0000110;
      "f":     s = 7'b0001110;
      "g":     s = 7'b0010000;
      "h":     s = 7'b0001011;
      "i":     s = 7'b1111011;
      "j":     s = 7'b1100001;
      "l":     s = 7'b1000111;
      "n":     s = 7'b0101011;
      "o":     s = 7'b0100011;
      "p":     s = 7'b0001100;
      "q":     s = 7'b0011000;
      "r":     s = SEG_R;
      "s":     s = 7'b0010010;
      "t":     s = SEG_T;
      "u":     s = 7'b1100011;
      "y":     s = 7'b0010001;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Scan index 0 is the leftmost digit, so idx k drives AN[3-k] low.
  function automatic logic [3:0] an_onehot(input logic [1:0] idx);
    return ~(4'b1000 >> idx);
  endfunction

endpackage

// File: rtl/sseg_glyph.sv
// Combinational ASCII-to-segment font lookup (active-low outputs).
module sseg_glyph (
  input  logic [7:0] ascii,
  output logic [6:0] seg
);
  import sseg_pkg::*;

  always_comb begin
    seg = ascii_to_seg(ascii);
  end

endmodule

// File: rtl/sseg_ascii_scan.sv
// Time-multiplexed 4-digit common-anode display driver for a 32-bit ASCII word,
// with per-digit blink and decimal points and a frame-coherent input shadow.
module sseg_ascii_scan #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter int unsigned BLINK_HZ   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] WORD,
  input  logic [3:0]  BLINK,
  input  logic [3:0]  DOTS,
  output logic [6:0]  SEG,
  output logic [3:0]  AN,
  output logic        DP
);
  import sseg_pkg::*;

  localparam int unsigned DIV  = CLK_HZ / REFRESH_HZ;
  localparam int unsigned HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned PW   = (DIV  > 1) ? $clog2(DIV)  : 1;
  localparam int unsigned BW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [PW-1:0] pre_cnt;
  logic [BW-1:0] blk_cnt;
  logic          phase;
  logic [1:0]    idx;
  logic [31:0]   sh_word;
  logic [3:0]    sh_blink;
  logic [3:0]    sh_dots;

  logic          tick;
  logic          blk_wrap;
  logic [1:0]    digit;
  logic [7:0]    cur_char;
  logic [6:0]    glyph;
  logic          blanked;

  assign tick     = (pre_cnt == PW'(DIV - 1));
  assign blk_wrap = (blk_cnt == BW'(HALF - 1));

  always_comb begin
    digit    = 2'd3 - idx;
    cur_char = sh_word[{digit, 3'b000} +: 8];
    blanked  = phase & sh_blink[digit];
  end

  sseg_glyph u_glyph (
    .ascii (cur_char),
    .seg   (glyph)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_cnt  <= '0;
      blk_cnt  <= '0;
      phase    <= 1'b0;
      idx      <= '0;
      sh_word  <= 32'h20202020;
      sh_blink <= '0;
      sh_dots  <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (blk_wrap) begin
        blk_cnt <= '0;
        phase   <= ~phase;
      end else begin
        blk_cnt <= blk_cnt + 1'b1;
      end
      if (tick) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          sh_word  <= WORD;
          sh_blink <= BLINK;
          sh_dots  <= DOTS;
        end
      end
    end
  end

  // The cycle after a tick is fully dark (anodes, segments and DP) so the
  // outgoing digit's pattern never leaks onto the incoming anode.
  always_ff @(posedge CLK) begin
    if (RST || tick) begin
      SEG <= SEG_BLANK;
      AN  <= '1;
      DP  <= 1'b1;
    end else begin
      AN  <= an_onehot(idx);
      SEG <= blanked ? SEG_BLANK : glyph;
      DP  <= blanked ? 1'b1 : ~sh_dots[digit];
    end
  end

endmodule

// File: tb/tb_sseg_ascii_scan.sv
// Self-checking bench for sseg_ascii_scan at DIV=4, HALF=20.
module tb_sseg_ascii_scan;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] WORD;
  logic [3:0]  BLINK;
  logic [3:0]  DOTS;
  logic [6:0]  SEG;
  logic [3:0]  AN;
  logic        DP;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [27:0] ROW_BLANK = {4{7'h7F}};
  localparam logic [27:0] ROW_EIGHT = {4{7'b0000000}};
  localparam logic [27:0] ROW_DASH  = {4{7'b0111111}};

  typedef struct {
    string       name;
    logic [31:0] word;
    logic [3:0]  blink;
    logic [3:0]  dots;
    logic [27:0] row;   // expected glyphs, leftmost digit in [27:21]
  } vec_t;

  vec_t vecs[6];

  sseg_ascii_scan #(
    .CLK_HZ     (1000),
    .REFRESH_HZ (250),
    .BLINK_HZ   (25)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .WORD  (WORD),
    .BLINK (BLINK),
    .DOTS  (DOTS),
    .SEG   (SEG),
    .AN    (AN),
    .DP    (DP)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  // n counts samples since the last reset edge; row/blk/dts describe the
  // shadow contents that should be on screen for that sample.
  task automatic check_sample(input string tag, input int n, input logic [27:0] row,
                              input logic [3:0] blk, input logic [3:0] dts);
    int         pos;
    int         idx;
    int         d;
    bit         ph;
    bit         blanked;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    pos = n % 4;
    idx = (n / 4) % 4;
    d   = 3 - idx;
    ph  = (n >= 1) ? (((n - 1) / 20) % 2 == 1) : 1'b0;
    case (idx)
      0:       exp_an = 4'b0111;
      1:       exp_an = 4'b1011;
      2:       exp_an = 4'b1101;
      default: exp_an = 4'b1110;
    endcase
    if (pos == 0) exp_an = 4'b1111;
    blanked = ph && blk[d];
    exp_seg = blanked ? 7'h7F : row[d*7 +: 7];
    exp_dp  = (pos == 0 || blanked) ? 1'b1 : ~dts[d];

    n_cmp++;
    if (AN !== exp_an) begin
      n_bad++;
      $display("FAIL %s AN n=%0d: got %b want %b", tag, n, AN, exp_an);
    end
    if (pos != 0 || n == 0) begin
      n_cmp++;
      if (SEG !== exp_seg) begin
        n_bad++;
        $display("FAIL %s SEG n=%0d: got %b want %b", tag, n, SEG, exp_seg);
      end
    end
    n_cmp++;
    if (DP !== exp_dp) begin
      n_bad++;
      $display("FAIL %s DP n=%0d: got %b want %b", tag, n, DP, exp_dp);
    end
  endtask

  initial begin
    vecs[0] = '{"data",  "data", 4'b0000, 4'b0000,
                {7'b0100001, 7'b0001000, 7'b0000111, 7'b0001000}};
    vecs[1] = '{"r0",    "  r0", 4'b0000, 4'b0000,
                {7'h7F, 7'h7F, 7'b0101111, 7'b1000000}};
    vecs[2] = '{"blink", "8888", 4'b0001, 4'b0000, ROW_EIGHT};
    vecs[3] = '{"dots",  "data", 4'b0000, 4'b1000,
                {7'b0100001, 7'b0001000, 7'b0000111, 7'b0001000}};
    vecs[4] = '{"fold",  "Q?zZ", 4'b0000, 4'b0000,
                {7'b0011000, 7'h7F, 7'h7F, 7'h7F}};
    vecs[5] = '{"mix",   "-_19", 4'b0000, 4'b0000,
                {7'b0111111, 7'b1110111, 7'b1111001, 7'b0010000}};

    RST = 1'b1; WORD = '0; BLINK = '0; DOTS = '0;

    // Three frames per vector: blank first frame, then two frames of the word
    // (the blink vector sees both phases on AN[0]).
    for (int v = 0; v < 6; v++) begin
      WORD = vecs[v].word; BLINK = vecs[v].blink; DOTS = vecs[v].dots;
      do_reset();
      for (int n = 0; n < 48; n++) begin
        if (n < 16) check_sample(vecs[v].name, n, ROW_BLANK, 4'b0000, 4'b0000);
        else        check_sample(vecs[v].name, n, vecs[v].row, vecs[v].blink, vecs[v].dots);
        step();
      end
    end

    // Mid-frame change: current frame keeps the old word.
    BLINK = '0; DOTS = '0; WORD = "8888";
    do_reset();
    for (int n = 0; n < 48; n++) begin
      if (n == 22) WORD = "----";
      check_sample("midframe", n, (n < 16) ? ROW_BLANK : (n < 32) ? ROW_EIGHT : ROW_DASH,
                   4'b0000, 4'b0000);
      step();
    end

    // Change in the capture-tick cycle is taken.
    WORD = "8888";
    do_reset();
    for (int n = 0; n < 32; n++) begin
      if (n == 15) WORD = "----";
      check_sample("captick", n, (n < 16) ? ROW_BLANK : ROW_DASH, 4'b0000, 4'b0000);
      step();
    end

    // Change one cycle after the capture tick waits a full frame.
    WORD = "8888";
    do_reset();
    for (int n = 0; n < 48; n++) begin
      if (n == 16) WORD = "----";
      check_sample("postcap", n, (n < 16) ? ROW_BLANK : (n < 32) ? ROW_EIGHT : ROW_DASH,
                   4'b0000, 4'b0000);
      step();
    end

    // Reset pulse while idx=2, then a fresh scan with a blank first frame.
    WORD = "data"; DOTS = 4'b1000;
    do_reset();
    for (int n = 0; n < 26; n++) begin
      check_sample("prerst", n, (n < 16) ? ROW_BLANK : vecs[3].row,
                   4'b0000, (n < 16) ? 4'b0000 : 4'b1000);
      step();
    end
    // n=26 is inside idx=2 of frame 2
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int n = 0; n < 32; n++) begin
      check_sample("postrst", n, (n < 16) ? ROW_BLANK : vecs[3].row,
                   4'b0000, (n < 16) ? 4'b0000 : 4'b1000);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
